// File: rtl/bg_pixel_fetch_if.sv
// Memory-side bus of the background pixel fetcher: tile map read port and
// tile pixel ROM read port. Read data must be valid one Clk after its address.
interface bg_pixel_fetch_if #(
    parameter int MAP_AW = 13,
    parameter int ROM_AW = 15
);
    logic [MAP_AW-1:0] map_addr;
    logic [7:0]        map_data;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;

    modport master (
        output map_addr,
        output rom_addr,
        input  map_data,
        input  rom_data
    );

    modport slave (
        input  map_addr,
        input  rom_addr,
        output map_data,
        output rom_data
    );
endinterface

// File: rtl/bg_pixel_fetch.sv
// Three-stage background pixel source: tile map lookup, tile pixel ROM lookup,
// palette index output with aligned coordinates. Optional macro BG_TILE_FLIP_EN.
module bg_pixel_fetch #(
    parameter int MAP_W  = 40,
    parameter int MAP_H  = 30,
    parameter int LEVELS = 4,
    parameter int MAP_AW = 13,
    parameter int ROM_AW = 15
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [1:0]  level_sel,
    bg_pixel_fetch_if.master mem,
    output logic [7:0]  bgColor,
    output logic [9:0]  DrawX_d,
    output logic [9:0]  DrawY_d,
    output logic        pix_valid
);
    localparam int          SUM_W       = 16;
    localparam int          LEVEL_SIZE  = MAP_W * MAP_H;
    localparam logic [2:0]  LEVEL_LIMIT = 3'(LEVELS);
    localparam int          COORD_STAGES = 3;

    // ---------------- stage S0: tile map address ----------------
    logic [5:0]       tx;
    logic [5:0]       ty;
    logic [SUM_W-1:0] row_off;
    logic [SUM_W-1:0] level_base;
    logic [SUM_W-1:0] map_sum;
    logic             vis_next;
    logic             frame_start;
    logic             level_ok;

    logic [1:0]        active_level_reg;
    logic [MAP_AW-1:0] map_addr_reg;
    logic [3:0]        s0_px_reg;
    logic [3:0]        s0_py_reg;
    logic              s0_vis_reg;

    assign tx = DrawX[9:4];
    assign ty = DrawY[9:4];

    generate
        if (MAP_W == 40) begin : g_row_shift
            assign row_off = (SUM_W'(ty) << 5) + (SUM_W'(ty) << 3);
        end else begin : g_row_mul
            assign row_off = SUM_W'(ty) * SUM_W'(MAP_W);
        end
    endgenerate

    assign level_base  = SUM_W'(active_level_reg) * SUM_W'(LEVEL_SIZE);
    assign map_sum     = level_base + row_off + SUM_W'(tx);
    assign vis_next    = (DrawX < 10'd640) && (DrawY < 10'd480);
    assign frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);
    assign level_ok    = ({1'b0, level_sel} < LEVEL_LIMIT);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            active_level_reg <= '0;
            map_addr_reg     <= '0;
            s0_px_reg        <= '0;
            s0_py_reg        <= '0;
            s0_vis_reg       <= 1'b0;
        end else begin
            // The map address uses the level in force before this sample, so a
            // new level only affects pixels after the frame-start sample.
            if (frame_start && level_ok) begin
                active_level_reg <= level_sel;
            end
            map_addr_reg <= map_sum[MAP_AW-1:0];
            s0_px_reg    <= DrawX[3:0];
            s0_py_reg    <= DrawY[3:0];
            s0_vis_reg   <= vis_next;
        end
    end

    assign mem.map_addr = map_addr_reg;

    // ---------------- stage S1: tile pixel ROM address ----------------
    logic [6:0]        tile_id;
    logic [3:0]        px_eff;
    logic [ROM_AW-1:0] rom_addr_reg;
    logic              s1_vis_reg;

    assign tile_id = mem.map_data[6:0];

`ifdef BG_TILE_FLIP_EN
    assign px_eff = mem.map_data[7] ? (4'd15 - s0_px_reg) : s0_px_reg;
`else
    logic flip_unused;
    assign flip_unused = mem.map_data[7];
    assign px_eff      = s0_px_reg;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_reg <= '0;
            s1_vis_reg   <= 1'b0;
        end else begin
            rom_addr_reg <= ROM_AW'({tile_id, s0_py_reg, px_eff});
            s1_vis_reg   <= s0_vis_reg;
        end
    end

    assign mem.rom_addr = rom_addr_reg;

    // ---------------- stage S2: colour output ----------------
    logic [7:0] bg_color_reg;
    logic       pix_valid_reg;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bg_color_reg  <= 8'h00;
            pix_valid_reg <= 1'b0;
        end else begin
            bg_color_reg  <= s1_vis_reg ? mem.rom_data : 8'h00;
            pix_valid_reg <= s1_vis_reg;
        end
    end

    assign bgColor   = bg_color_reg;
    assign pix_valid = pix_valid_reg;

    // ---------------- coordinate delay line (one slot per stage) ----------------
    genvar gi;
    generate
        for (gi = 0; gi < COORD_STAGES; gi++) begin : g_coord_pipe
            logic [9:0] x_reg;
            logic [9:0] y_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge Clk or negedge Reset_n) begin
                    if (!Reset_n) begin
                        x_reg <= '0;
                        y_reg <= '0;
                    end else begin
                        x_reg <= DrawX;
                        y_reg <= DrawY;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge Clk or negedge Reset_n) begin
                    if (!Reset_n) begin
                        x_reg <= '0;
                        y_reg <= '0;
                    end else begin
                        x_reg <= g_coord_pipe[gi-1].x_reg;
                        y_reg <= g_coord_pipe[gi-1].y_reg;
                    end
                end
            end
        end
    endgenerate

    assign DrawX_d = g_coord_pipe[COORD_STAGES-1].x_reg;
    assign DrawY_d = g_coord_pipe[COORD_STAGES-1].y_reg;

endmodule

// File: tb/tb_bg_pixel_fetch.sv
// Self-checking bench for bg_pixel_fetch: random and directed coordinates checked
// against a per-pixel arithmetic model of the two-level tile lookup.
module tb_bg_pixel_fetch;
    localparam int MAP_W  = 40;
    localparam int MAP_H  = 30;
    localparam int LEVELS = 3;
    localparam int MAP_AW = 13;
    localparam int ROM_AW = 15;

    typedef struct {
        int                x;
        int                y;
        logic [MAP_AW-1:0] map_addr;
        logic [ROM_AW-1:0] rom_addr;
        logic [7:0]        color;
        logic              vis;
    } exp_t;

    logic       Clk;
    logic       Reset_n;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [1:0] level_sel;
    logic [7:0] bgColor;
    logic [9:0] DrawX_d;
    logic [9:0] DrawY_d;
    logic       pix_valid;

    logic [7:0] map_mem [0:(1<<MAP_AW)-1];
    logic [7:0] rom_mem [0:(1<<ROM_AW)-1];

    exp_t hist[$];
    int   model_level;
    int   vectors;
    int   miscompares;

    bg_pixel_fetch_if #(.MAP_AW(MAP_AW), .ROM_AW(ROM_AW)) mem_if ();

    assign mem_if.map_data = map_mem[mem_if.map_addr];
    assign mem_if.rom_data = rom_mem[mem_if.rom_addr];

    bg_pixel_fetch #(
        .MAP_W(MAP_W), .MAP_H(MAP_H), .LEVELS(LEVELS),
        .MAP_AW(MAP_AW), .ROM_AW(ROM_AW)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .DrawX(DrawX),
        .DrawY(DrawY),
        .level_sel(level_sel),
        .mem(mem_if.master),
        .bgColor(bgColor),
        .DrawX_d(DrawX_d),
        .DrawY_d(DrawY_d),
        .pix_valid(pix_valid)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Reference: what the pixel at (x,y) in level lvl should look like.
    function automatic exp_t model(input int x, input int y, input int lvl);
        exp_t e;
        int maddr;
        int tile;
        int col;
        int raddr;
        e.x   = x;
        e.y   = y;
        e.vis = (x < 640) && (y < 480);
        maddr = (lvl * MAP_W * MAP_H + (y / 16) * MAP_W + x / 16) % (1 << MAP_AW);
        e.map_addr = MAP_AW'(maddr);
        tile = int'(map_mem[maddr]) % 128;
        col  = x % 16;
`ifdef BG_TILE_FLIP_EN
        if (map_mem[maddr][7]) col = 15 - col;
`endif
        raddr = tile * 256 + (y % 16) * 16 + col;
        e.rom_addr = ROM_AW'(raddr);
        e.color = e.vis ? rom_mem[raddr] : 8'h00;
        return e;
    endfunction

    // One pixel per clock: check in-flight pixels at their stage, then drive a new one.
    task automatic apply(input int x, input int y, input int sel);
        exp_t e;
        @(negedge Clk);
        if (hist.size() >= 1) begin
            e = hist[hist.size()-1];
            if (e.vis) begin
                vectors++;
                if (mem_if.map_addr !== e.map_addr) begin
                    miscompares++;
                    $display("FAIL map_addr (%0d,%0d): got %0d expected %0d", e.x, e.y, mem_if.map_addr, e.map_addr);
                end
            end
        end
        if (hist.size() >= 2) begin
            e = hist[hist.size()-2];
            if (e.vis) begin
                vectors++;
                if (mem_if.rom_addr !== e.rom_addr) begin
                    miscompares++;
                    $display("FAIL rom_addr (%0d,%0d): got %h expected %h", e.x, e.y, mem_if.rom_addr, e.rom_addr);
                end
            end
        end
        if (hist.size() >= 3) begin
            e = hist.pop_front();
            vectors++;
            if (bgColor !== e.color || pix_valid !== e.vis ||
                DrawX_d !== 10'(e.x) || DrawY_d !== 10'(e.y)) begin
                miscompares++;
                $display("FAIL pixel (%0d,%0d): got color=%h valid=%b xd=%0d yd=%0d expected color=%h valid=%b",
                         e.x, e.y, bgColor, pix_valid, DrawX_d, DrawY_d, e.color, e.vis);
            end
        end else begin
            // Pipeline still holding post-reset zeros.
            vectors++;
            if (pix_valid !== 1'b0 || bgColor !== 8'h00) begin
                miscompares++;
                $display("FAIL post_reset_fill: got valid=%b color=%h expected valid=0 color=00", pix_valid, bgColor);
            end
        end
        DrawX     = 10'(x);
        DrawY     = 10'(y);
        level_sel = 2'(sel);
        hist.push_back(model(x, y, model_level));
        if (x == 0 && y == 0 && sel < LEVELS) model_level = sel;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) apply(700, 500, 0);
    endtask

    task automatic test_reset();
        map_mem[0]       = 8'h05;
        rom_mem[5 * 256] = 8'hA3;
        apply(20, 20, 0);
        apply(21, 20, 0);
        apply(22, 20, 0);
        apply(23, 20, 0);
        @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        vectors++;
        if (mem_if.map_addr !== '0 || mem_if.rom_addr !== '0 || bgColor !== 8'h00 ||
            DrawX_d !== 10'd0 || DrawY_d !== 10'd0 || pix_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got map=%0d rom=%0d color=%h xd=%0d yd=%0d valid=%b expected all 0",
                     mem_if.map_addr, mem_if.rom_addr, bgColor, DrawX_d, DrawY_d, pix_valid);
        end
        DrawX = 10'd700;
        DrawY = 10'd500;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        hist.delete();
        model_level = 0;
        apply(0, 0, 0);
        apply(1, 0, 0);
        apply(2, 0, 0);
        apply(3, 0, 0);
        vectors++;
        if (bgColor !== 8'hA3 || pix_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL first_pixel: got color=%h valid=%b expected color=a3 valid=1", bgColor, pix_valid);
        end
        drain();
    endtask

    task automatic test_level_switch();
        map_mem[1322] = 8'h09;
        apply(0, 0, 1);
        apply(37, 50, 1);
        @(posedge Clk);
        #1;
        vectors++;
        if (mem_if.map_addr !== 13'd1322) begin
            miscompares++;
            $display("FAIL level1_map_addr: got %0d expected 1322", mem_if.map_addr);
        end
        apply(100, 10, 2);
        for (int i = 0; i < 20; i++) apply($urandom_range(0, 639), $urandom_range(0, 479), 2);
        apply(0, 0, 2);
        for (int i = 0; i < 20; i++) apply($urandom_range(0, 639), $urandom_range(0, 479), 2);
        apply(0, 0, 3);
        apply(16, 0, 3);
        @(posedge Clk);
        #1;
        vectors++;
        if (mem_if.map_addr !== 13'd2401) begin
            miscompares++;
            $display("FAIL ignored_level: got %0d expected 2401", mem_if.map_addr);
        end
        drain();
    endtask

    task automatic test_blanking();
        drain();
        for (int i = 0; i < (1 << ROM_AW); i++) rom_mem[i] = 8'hFF;
        apply(700, 100, 0);
        apply(10, 490, 0);
        apply(639, 479, 0);
        apply(640, 479, 0);
        apply(639, 480, 0);
        apply(799, 524, 0);
        drain();
        for (int i = 0; i < (1 << ROM_AW); i++) rom_mem[i] = 8'($urandom);
    endtask

    task automatic test_flip();
        int maddr;
        logic [ROM_AW-1:0] want;
        drain();
        maddr = model_level * MAP_W * MAP_H + 2 * MAP_W;
        map_mem[maddr] = 8'h85;
`ifdef BG_TILE_FLIP_EN
        want = {7'd5, 4'd8, 4'd12};
`else
        want = {7'd5, 4'd8, 4'd3};
`endif
        apply(3, 40, 0);
        apply(4, 40, 0);
        @(posedge Clk);
        #1;
        vectors++;
        if (mem_if.rom_addr !== want) begin
            miscompares++;
            $display("FAIL flip_rom_addr: got %h expected %h", mem_if.rom_addr, want);
        end
        for (int x = 0; x < 16; x++) apply(x, 41, 0);
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) apply(0, 0, $urandom_range(0, 3));
            else apply($urandom_range(0, 799), $urandom_range(0, 524), $urandom_range(0, 3));
        end
        drain();
    endtask

    task automatic test_back_to_back();
        for (int y = 479; y <= 480; y++)
            for (int x = 0; x < 800; x++) apply(x, y, 1);
        apply(799, 524, 1);
        apply(0, 0, 1);
        for (int x = 0; x < 40; x++) apply(x, 0, 1);
        drain();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_level = 0;
        Reset_n     = 1'b0;
        DrawX       = 10'd700;
        DrawY       = 10'd500;
        level_sel   = 2'd0;
        for (int i = 0; i < (1 << MAP_AW); i++) map_mem[i] = 8'($urandom);
        for (int i = 0; i < (1 << ROM_AW); i++) rom_mem[i] = 8'($urandom);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        test_reset();
        test_level_switch();
        test_blanking();
        test_flip();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
